// File: rtl/fetch_controller_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
package fetch_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam logic [31:0] PC_STEP = 32'd4;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    HALTED
  } fetch_state_e;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [INSTR_W-1:0] pc_plus4;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_controller_if.sv
// Instruction-memory and decode handshake bundle between fetch and the rest of the core.
interface fetch_if;

  logic [fetch_pkg::INSTR_W-1:0] imem_addr;
  logic [fetch_pkg::INSTR_W-1:0] imem_rdata;
  logic                          branch_taken;
  logic [fetch_pkg::INSTR_W-1:0] branch_addr;
  logic                          id_valid;
  logic                          id_ready;
  logic [fetch_pkg::INSTR_W-1:0] id_instr;
  logic [fetch_pkg::INSTR_W-1:0] id_pc_plus4;

  modport master (
    output imem_addr, id_valid, id_instr, id_pc_plus4,
    input  imem_rdata, branch_taken, branch_addr, id_ready
  );

  modport slave (
    input  imem_addr, id_valid, id_instr, id_pc_plus4,
    output imem_rdata, branch_taken, branch_addr, id_ready
  );

endinterface

// File: rtl/fetch_controller_queue.sv
// Small synchronous FIFO of fetched words; clear wins over push and pop.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             clear,
  input  fetch_entry_t     push_data,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count,
  output fetch_entry_t     head
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  fetch_entry_t     mem_q [DEPTH];
  fetch_entry_t     mem_d [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);
  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    if (clear) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/fetch_controller.sv
// Fetch sequencer: owns the PC, the start/halt run state and the fetch counter,
// and feeds fetched words through a small queue toward decode.
module fetch_controller
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'd0,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        halt_req,
  fetch_if.master     bus,
  output logic        running,
  output logic [31:0] fetch_count
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  fetch_state_e     state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [31:0]      fetch_count_q, fetch_count_d;
  logic             running_q, running_d;

  logic             q_push, q_pop, q_clear, q_full, q_empty;
  logic [CNT_W-1:0] q_count;
  fetch_entry_t     q_head, push_entry;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    fetch_count_d = fetch_count_q;
    q_push        = 1'b0;
    q_clear       = 1'b0;
    q_pop         = !q_empty && bus.id_ready;
    push_entry    = '{instr: bus.imem_rdata, pc_plus4: pc_q + PC_STEP};
    unique case (state_q)
      IDLE, HALTED: begin
        if (start) begin
          state_d       = RUN;
          pc_d          = RESET_PC;
          q_clear       = 1'b1;
          fetch_count_d = '0;
        end
      end
      RUN: begin
        // Redirect beats both halt and push; a halt in the same cycle still drains.
        if (bus.branch_taken) begin
          q_clear = 1'b1;
          pc_d    = {bus.branch_addr[31:2], 2'b00};
          if (halt_req) state_d = DRAIN;
        end else if (halt_req) begin
          state_d = DRAIN;
        end else if (!q_full || q_pop) begin
          q_push        = 1'b1;
          pc_d          = pc_q + PC_STEP;
          fetch_count_d = fetch_count_q + 32'd1;
        end
      end
      DRAIN: begin
        // Leave as soon as the final entry is being popped, not a cycle later.
        if (bus.branch_taken) begin
          q_clear = 1'b1;
          state_d = HALTED;
        end else if (q_empty || (q_pop && q_count == CNT_W'(1))) begin
          state_d = HALTED;
        end
      end
      default: state_d = IDLE;
    endcase
    running_d = (state_d == RUN) || (state_d == DRAIN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      pc_q          <= RESET_PC;
      fetch_count_q <= '0;
      running_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      fetch_count_q <= fetch_count_d;
      running_q     <= running_d;
    end
  end

  fetch_queue #(
    .DEPTH(DEPTH)
  ) u_queue (
    .clk      (clk),
    .rst      (rst),
    .push     (q_push),
    .pop      (q_pop),
    .clear    (q_clear),
    .push_data(push_entry),
    .full     (q_full),
    .empty    (q_empty),
    .count    (q_count),
    .head     (q_head)
  );

  assign bus.imem_addr   = pc_q;
  assign bus.id_valid    = !q_empty;
  assign bus.id_instr    = q_head.instr;
  assign bus.id_pc_plus4 = q_head.pc_plus4;
  assign running         = running_q;
  assign fetch_count     = fetch_count_q;

endmodule

// File: tb/tb_fetch_controller.sv
// Directed plus randomized checks of fetch_controller against a queue-of-PCs reference model.
module tb_fetch_controller;

  localparam logic [31:0] TB_RESET_PC = 32'd0;
  localparam int unsigned TB_DEPTH    = 2;
  localparam int M_IDLE = 0, M_RUN = 1, M_DRAIN = 2, M_HALTED = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        halt_req = 1'b0;
  logic        running;
  logic [31:0] fetch_count;

  fetch_if bus();

  int n_checks = 0;
  int n_fail   = 0;

  int          m_mode;
  logic [31:0] m_pc;
  logic [31:0] m_cnt;
  logic [31:0] m_q[$];
  logic [31:0] halted_pc;

  fetch_controller #(
    .RESET_PC(TB_RESET_PC),
    .DEPTH   (TB_DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .halt_req   (halt_req),
    .bus        (bus),
    .running    (running),
    .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0F0F;
  endfunction

  assign bus.imem_rdata = mem_word(bus.imem_addr);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic reset_model();
    m_mode = M_IDLE;
    m_pc   = TB_RESET_PC;
    m_cnt  = 32'd0;
    m_q.delete();
  endtask

  task automatic chk_reset_values(input string ctx);
    chk({ctx, ":imem_addr"},   bus.imem_addr, TB_RESET_PC);
    chk({ctx, ":id_valid"},    32'(bus.id_valid), 32'd0);
    chk({ctx, ":id_instr"},    bus.id_instr, 32'd0);
    chk({ctx, ":id_pc_plus4"}, bus.id_pc_plus4, 32'd0);
    chk({ctx, ":running"},     32'(running), 32'd0);
    chk({ctx, ":fetch_count"}, fetch_count, 32'd0);
  endtask

  task automatic check_model(input string ctx);
    chk({ctx, ":imem_addr"},   bus.imem_addr, m_pc);
    chk({ctx, ":id_valid"},    32'(bus.id_valid), 32'(m_q.size() > 0));
    chk({ctx, ":running"},     32'(running), 32'(m_mode == M_RUN || m_mode == M_DRAIN));
    chk({ctx, ":fetch_count"}, fetch_count, m_cnt);
    if (m_q.size() > 0) begin
      chk({ctx, ":id_instr"},    bus.id_instr, mem_word(m_q[0]));
      chk({ctx, ":id_pc_plus4"}, bus.id_pc_plus4, m_q[0] + 32'd4);
    end
  endtask

  // Next-cycle behaviour derived from the current inputs and the modelled queue of fetch PCs.
  task automatic model_update();
    int sz  = m_q.size();
    bit pop = (sz > 0) && bus.id_ready;
    case (m_mode)
      M_IDLE, M_HALTED: begin
        if (start) begin
          m_mode = M_RUN;
          m_pc   = TB_RESET_PC;
          m_cnt  = 32'd0;
          m_q.delete();
        end
      end
      M_RUN: begin
        if (bus.branch_taken) begin
          m_q.delete();
          m_pc = {bus.branch_addr[31:2], 2'b00};
          if (halt_req) m_mode = M_DRAIN;
        end else begin
          if (pop) void'(m_q.pop_front());
          if (halt_req) begin
            m_mode = M_DRAIN;
          end else if (sz < int'(TB_DEPTH) || pop) begin
            m_q.push_back(m_pc);
            m_pc  = m_pc + 32'd4;
            m_cnt = m_cnt + 32'd1;
          end
        end
      end
      M_DRAIN: begin
        if (bus.branch_taken) begin
          m_q.delete();
          m_mode = M_HALTED;
        end else begin
          if (pop) void'(m_q.pop_front());
          if (m_q.size() == 0) m_mode = M_HALTED;
        end
      end
      default: ;
    endcase
  endtask

  task automatic tick(input string ctx);
    model_update();
    @(posedge clk);
    #1;
    check_model(ctx);
  endtask

  initial begin
    bus.id_ready     = 1'b0;
    bus.branch_taken = 1'b0;
    bus.branch_addr  = 32'd0;
    reset_model();

    repeat (2) @(posedge clk);
    #1;
    chk_reset_values("reset");
    rst = 1'b0;
    check_model("after_reset");

    // Free run
    start = 1'b1;
    bus.id_ready = 1'b1;
    tick("start");
    start = 1'b0;
    chk("start_running", 32'(running), 32'd1);
    chk("start_addr", bus.imem_addr, 32'd0);
    chk("start_nohead", 32'(bus.id_valid), 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick("free");
      chk("free_pc_plus4", bus.id_pc_plus4, 32'(4 * (i + 1)));
    end
    chk("free_count", fetch_count, 32'd4);

    // Halt with two entries queued
    bus.id_ready = 1'b0;
    repeat (2) tick("fill_for_halt");
    halted_pc = m_pc;
    halt_req = 1'b1;
    bus.id_ready = 1'b1;
    tick("halt");
    halt_req = 1'b0;
    chk("drain_running", 32'(running), 32'd1);
    tick("drain");
    chk("halted_running", 32'(running), 32'd0);
    chk("halted_empty", 32'(bus.id_valid), 32'd0);
    repeat (3) tick("halted");
    chk("halted_pc_frozen", bus.imem_addr, halted_pc);
    start = 1'b1;
    tick("restart");
    start = 1'b0;
    chk("restart_addr", bus.imem_addr, TB_RESET_PC);
    chk("restart_count", fetch_count, 32'd0);

    // Back-pressure
    bus.id_ready = 1'b0;
    repeat (5) tick("stall");
    chk("stall_addr", bus.imem_addr, 32'd8);
    chk("stall_head", bus.id_pc_plus4, 32'd4);
    bus.id_ready = 1'b1;
    tick("release");
    chk("release_head1", bus.id_pc_plus4, 32'd8);
    tick("release");
    chk("release_head2", bus.id_pc_plus4, 32'd12);

    // Branch with full queue, no pop
    bus.id_ready = 1'b0;
    repeat (3) tick("fill_branch");
    bus.branch_taken = 1'b1;
    bus.branch_addr  = 32'h93;
    tick("branch");
    bus.branch_taken = 1'b0;
    chk("branch_target", bus.imem_addr, 32'h90);
    chk("branch_bubble", 32'(bus.id_valid), 32'd0);
    tick("branch_fetch");
    chk("branch_head_valid", 32'(bus.id_valid), 32'd1);
    chk("branch_head", bus.id_pc_plus4, 32'h94);

    // Branch and pop together while full
    repeat (2) tick("fill_branch_pop");
    bus.id_ready     = 1'b1;
    bus.branch_taken = 1'b1;
    bus.branch_addr  = 32'h200;
    tick("branch_pop");
    bus.branch_taken = 1'b0;
    chk("branch_pop_bubble", 32'(bus.id_valid), 32'd0);
    tick("branch_pop_fetch");
    chk("branch_pop_head", bus.id_pc_plus4, 32'h204);
    chk("branch_pop_instr", bus.id_instr, mem_word(32'h200));

    // PC wrap
    bus.branch_taken = 1'b1;
    bus.branch_addr  = 32'hFFFF_FFFC;
    tick("wrap_branch");
    bus.branch_taken = 1'b0;
    chk("wrap_target", bus.imem_addr, 32'hFFFF_FFFC);
    tick("wrap_fetch");
    chk("wrap_next_addr", bus.imem_addr, 32'd0);
    chk("wrap_pc_plus4", bus.id_pc_plus4, 32'd0);

    // Asynchronous reset mid-run with the queue full
    bus.id_ready = 1'b0;
    repeat (3) tick("fill_reset");
    #2;
    rst = 1'b1;
    #1;
    chk_reset_values("async_reset");
    reset_model();
    @(posedge clk);
    #1;
    check_model("held_reset");
    rst = 1'b0;

    // Randomized traffic
    for (int c = 0; c < 400; c++) begin
      start            = ($urandom_range(0, 19) == 0);
      bus.branch_taken = ($urandom_range(0, 9) == 0);
      bus.branch_addr  = $urandom;
      halt_req         = !bus.branch_taken && ($urandom_range(0, 24) == 0);
      bus.id_ready     = ($urandom_range(0, 3) != 0);
      tick("random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_controller.md
# fetch_controller

Instruction-fetch sequencer for the pipelined ARM core. It owns the program counter, drives the address of the combinational instruction memory and buffers fetched words in a 2-entry queue toward the IF/ID register. It also handles branch redirect/flush, decode back-pressure and a start/halt run state machine.

## Interface
- `RESET_PC`, default 32'd0: PC value loaded on reset and on `start`.
- `DEPTH`, default 2: fetch queue entries; legal values 2 or 4.
- `clk` in 1: single clock, all state on rising edge.
- `rst` in 1: reset, asynchronous and active-high.
- `start` in 1: pulse; leave IDLE/HALTED, PC <= RESET_PC.
- `halt_req` in 1: pulse; stop fetching, drain queue.
- `imem_addr` out 32: fetch address to instruction memory, equals PC register.
- `imem_rdata` in 32: instruction at `imem_addr`, same-cycle combinational.
- `branch_taken` in 1: redirect request from EXE stage.
- `branch_addr` in 32: redirect target; bits [1:0] forced to 0.
- `id_valid` out 1: queue head valid.
- `id_ready` in 1: decode accepts head this cycle.
- `id_instr` out 32: queue head instruction.
- `id_pc_plus4` out 32: fetch address of head + 4.
- `running` out 1: state is RUN or DRAIN.
- `fetch_count` out 32: instructions pushed since last `start`, wraps.

## Operation
- States: IDLE (reset), RUN, DRAIN, HALTED.
- State transitions:
  - IDLE/HALTED + `start` → RUN, PC <= RESET_PC, queue cleared, `fetch_count` <= 0.
  - RUN + `halt_req` → DRAIN.
  - DRAIN + queue empty → HALTED.
  - `branch_taken` in DRAIN → queue flushed, go HALTED; PC unchanged.
- pop = `id_valid` && `id_ready`.
- push = state==RUN && !`branch_taken` && !`halt_req` && (count < DEPTH || pop).
- On push:
  - enqueue {`imem_rdata`, PC+4}.
  - PC <= PC+4.
  - `fetch_count`++.
- `branch_taken` in RUN (highest priority):
  - queue cleared; a same-cycle pop still counts as consumed.
  - PC <= {`branch_addr`[31:2], 2'b00}.
  - no push that cycle.
- Simultaneous push and pop at count==DEPTH is legal; count is unchanged.
- Push when full without a pop never happens; PC holds. This is the stall.
- `start` while in RUN/DRAIN is ignored. `halt_req` in IDLE/HALTED is ignored.
- PC and PC+4 arithmetic is modulo 2^32; 32'hFFFFFFFC + 4 → 0.
- `id_instr` and `id_pc_plus4` are don't-care while `id_valid`=0; they must not be X in simulation after reset.

## Timing
- Reset values:
  - state IDLE, PC=RESET_PC, count=0.
  - `id_valid`=0, `id_instr`=0, `id_pc_plus4`=0.
  - `running`=0, `fetch_count`=0.
  - `imem_addr`=RESET_PC.
- `id_valid`, `id_instr` and `id_pc_plus4` are registered queue-head outputs; there is no combinational path from `imem_rdata`.
- Fetch latency: address presented in cycle T → `id_valid` with that word in T+1, if the queue was empty.
- Branch penalty: `branch_taken` in T → `imem_addr`=target in T+1 → target word at head in T+2. `id_valid`=0 during T+1.
- `start` in T → RUN and `imem_addr`=RESET_PC in T+1 → first `id_valid` in T+2.
- `halt_req` in T → no push in T or later; HALTED the cycle after the last pop.
- `rst` asserted mid-operation clears everything immediately, with no pending pops.

## Structure
- Shared package `fetch_pkg` holds:
  - state enum {IDLE, RUN, DRAIN, HALTED}.
  - `INSTR_W`=32 and `PC_STEP`=4.
  - queue entry struct {instr, pc_plus4}.
- One sub-module, `fetch_queue`:
  - parameterised synchronous FIFO.
  - ports: push, pop, clear, full, empty, head.
  - clear has priority over push.
- The controller FSM, PC register and counter sit in the top module.

## Test plan
- Free run: `start`, `id_ready`=1 held, memory returns addr-derived words → heads at PCs 0, 4, 8, 12 on consecutive cycles; `id_pc_plus4` = 4, 8, 12, 16; `fetch_count`=4 after 4 cycles.
- Back-pressure: `id_ready`=0 for 5 cycles after start → queue fills to 2, `imem_addr` stalls at 8, head stays PC 0; release → PCs 0, 4, 8 in order with no loss or duplication.
- Branch: `branch_taken` with `branch_addr`=32'h93 while queue holds 2 → next `imem_addr`=32'h90, `id_valid`=0 one cycle, next head `id_pc_plus4`=32'h94.
- Branch and pop together when full → old entries are discarded, only the target stream follows.
- Halt/drain: `halt_req` with 2 entries queued, `id_ready`=1 → 2 pops, then HALTED, `running`=0, PC frozen; `start` → resumes at RESET_PC.
- Reset mid-run: assert `rst` between clock edges with queue full → all outputs at reset values before the next edge; PC wrap checked separately via `branch_addr`=32'hFFFFFFFC → next fetch at 0.
